// File: rtl/stack_ctrl_if.sv
// Stack controller request/memory bundle.
// The hwm signal exists only when STACK_HWM_EN is defined.
interface stack_ctrl_if #(
    parameter int AW = 8,
    parameter int BW = 3
);
    logic          push;
    logic          pop;
    logic [BW-1:0] burst_len;
    logic          sp_load_en;
    logic [AW-1:0] sp_load;
    logic          flag_clr;
    logic [AW-1:0] sp;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic          ovf;
    logic          unf;
`ifdef STACK_HWM_EN
    logic [AW-1:0] hwm;
`endif

    modport master (
`ifdef STACK_HWM_EN
        input  hwm,
`endif
        output push,
        output pop,
        output burst_len,
        output sp_load_en,
        output sp_load,
        output flag_clr,
        input  sp,
        input  busy,
        input  mem_addr,
        input  mem_we,
        input  mem_re,
        input  ovf,
        input  unf
    );

    modport slave (
`ifdef STACK_HWM_EN
        output hwm,
`endif
        input  push,
        input  pop,
        input  burst_len,
        input  sp_load_en,
        input  sp_load,
        input  flag_clr,
        output sp,
        output busy,
        output mem_addr,
        output mem_we,
        output mem_re,
        output ovf,
        output unf
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack-pointer controller: empty-ascending stack, push/pop bursts,
// sticky bound flags. Optional high-water mark under STACK_HWM_EN.
module stack_ctrl #(
    parameter int              AW          = 8,
    parameter logic [AW-1:0]   RST_SP      = AW'(8'h10),
    parameter logic [AW-1:0]   STACK_BASE  = AW'(8'h10),
    parameter logic [AW-1:0]   STACK_LIMIT = AW'(8'hFF),
    parameter int              BW          = 3
) (
    input  logic       clk,
    input  logic       reset,
    stack_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        POP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          can_push;
    logic          can_pop;
    logic [BW-1:0] n_words;

    assign can_push = (sp_q < STACK_LIMIT);
    assign can_pop  = (sp_q > STACK_BASE);
    assign n_words  = (bus.burst_len == '0) ? BW'(1) : bus.burst_len;

    // Next-state: idle acceptance, one word per busy cycle, flag updates
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (bus.flag_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.sp_load_en) begin
                    sp_d = bus.sp_load;
                end else if (bus.push && bus.pop) begin
                    state_d = IDLE;
                end else if (bus.push) begin
                    state_d = PUSH;
                    cnt_d   = n_words;
                end else if (bus.pop) begin
                    state_d = POP;
                    cnt_d   = n_words;
                end
            end
            PUSH: begin
                if (can_push) begin
                    sp_d  = sp_q + AW'(1);
                    cnt_d = cnt_q - BW'(1);
                    if (cnt_q == BW'(1)) state_d = IDLE;
                end else begin
                    ovf_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            POP: begin
                if (can_pop) begin
                    sp_d  = sp_q - AW'(1);
                    cnt_d = cnt_q - BW'(1);
                    if (cnt_q == BW'(1)) state_d = IDLE;
                end else begin
                    unf_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any burst at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= RST_SP;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.sp       = sp_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.mem_we   = (state_q == PUSH) && can_push;
    assign bus.mem_re   = (state_q == POP) && can_pop;
    assign bus.mem_addr = (state_q == POP) ? (sp_q - AW'(1)) : sp_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

`ifdef STACK_HWM_EN
    logic [AW-1:0] hwm_q, hwm_d;

    // High-water mark: raised by issued push words, reset to sp by flag_clr
    always_comb begin
        hwm_d = hwm_q;
        if (bus.flag_clr) hwm_d = sp_q;
        if (bus.mem_we && ((sp_q + AW'(1)) > hwm_d)) hwm_d = sp_q + AW'(1);
    end

    // High-water mark register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hwm_q <= RST_SP;
        else       hwm_q <= hwm_d;
    end

    assign bus.hwm = hwm_q;
`endif

endmodule
